// File: rtl/esp_dma32_pkg.sv
// Shared definitions for the ESP 32-bit DMA responder: FSM encoding,
// the only supported transfer size, error bit positions and the range test.
package esp_dma32_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2
  } dma_state_t;

  localparam logic [2:0] DMA_SIZE_WORD = 3'b010;

  localparam int ERR_BAD_SIZE = 0;
  localparam int ERR_RANGE    = 1;

  // Burst runs past the end of memory when index + length exceeds the depth.
  function automatic logic range_err(input logic [31:0] index,
                                     input logic [31:0] length,
                                     input logic [32:0] words);
    return ({1'b0, index} + {1'b0, length}) > words;
  endfunction

endpackage

// File: rtl/esp_dma32_sram.sv
// Single-port synchronous backing RAM, one cycle read latency.
// Read data holds its last value on write cycles.
module esp_dma32_sram
  import esp_dma32_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];

  // Storage array and registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end else begin
      o_rdata <= r_mem[i_addr];
    end
  end

endmodule

// File: rtl/esp_dma32_responder.sv
// DMA responder: serves read/write bursts from an ESP accelerator against
// a local SRAM, with a 2-entry read output buffer for back-pressure.
module esp_dma32_responder
  import esp_dma32_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dma_read_ctrl_valid,
  output logic        dma_read_ctrl_ready,
  input  logic [31:0] dma_read_ctrl_data_index,
  input  logic [31:0] dma_read_ctrl_data_length,
  input  logic [2:0]  dma_read_ctrl_data_size,
  output logic        dma_read_chnl_valid,
  output logic [31:0] dma_read_chnl_data,
  input  logic        dma_read_chnl_ready,
  input  logic        dma_write_ctrl_valid,
  output logic        dma_write_ctrl_ready,
  input  logic [31:0] dma_write_ctrl_data_index,
  input  logic [31:0] dma_write_ctrl_data_length,
  input  logic [2:0]  dma_write_ctrl_data_size,
  input  logic        dma_write_chnl_valid,
  input  logic [31:0] dma_write_chnl_data,
  output logic        dma_write_chnl_ready,
  output logic        busy,
  output logic [1:0]  err
);

  localparam int AW = $clog2(MEM_WORDS);

  dma_state_t    r_state, w_state_nxt;
  logic [31:0]   r_index, r_length, r_issued, r_done;
  logic          r_pend, r_out_v, r_skid_v;
  logic [31:0]   r_out_d, r_skid_d;
  logic [1:0]    r_err;
  logic          w_rd_hs, w_wr_hs, w_pop, w_wr_beat, w_issue, w_space, w_sram_we;
  logic [2:0]    w_occ;
  logic [AW-1:0] w_sram_addr, w_burst_addr;
  logic [31:0]   w_sram_rdata;
  logic          w_unused;

  assign w_rd_hs      = dma_read_ctrl_valid & dma_read_ctrl_ready;
  assign w_wr_hs      = dma_write_ctrl_valid & dma_write_ctrl_ready;
  assign w_pop        = r_out_v & dma_read_chnl_ready;
  assign w_wr_beat    = dma_write_chnl_valid & dma_write_chnl_ready;
  // Buffered beats plus the one in flight from SRAM must never exceed two.
  assign w_occ        = {2'b00, r_out_v} + {2'b00, r_skid_v} + {2'b00, r_pend};
  assign w_space      = (w_occ - {2'b00, w_pop}) < 3'd2;
  assign w_burst_addr = r_index[AW-1:0] + r_issued[AW-1:0];
  assign w_unused     = ^r_index[31:AW];

  assign dma_read_chnl_valid = r_out_v;
  assign dma_read_chnl_data  = r_out_d;
  assign err                 = r_err;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_rd_hs) begin
          w_state_nxt = ST_RD_BURST;
        end else if (w_wr_hs) begin
          w_state_nxt = ST_WR_BURST;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RD_BURST: begin
        if ((r_length == 32'd0) || (w_pop && (r_done == r_length - 32'd1))) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RD_BURST;
        end
      end
      ST_WR_BURST: begin
        if ((r_length == 32'd0) || (w_wr_beat && (r_issued == r_length - 32'd1))) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WR_BURST;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake readiness and SRAM control; beat 0 of a read is fetched in the
  // handshake cycle itself so data reaches the output two cycles later.
  always_comb begin
    dma_read_ctrl_ready  = 1'b0;
    dma_write_ctrl_ready = 1'b0;
    dma_write_chnl_ready = 1'b0;
    busy                 = 1'b1;
    w_issue              = 1'b0;
    w_sram_we            = 1'b0;
    w_sram_addr          = w_burst_addr;
    case (r_state)
      ST_IDLE: begin
        busy                 = 1'b0;
        dma_read_ctrl_ready  = rst;
        dma_write_ctrl_ready = rst & ~dma_read_ctrl_valid;
        if (rst && dma_read_ctrl_valid && (dma_read_ctrl_data_length != 32'd0)) begin
          w_issue     = 1'b1;
          w_sram_addr = dma_read_ctrl_data_index[AW-1:0];
        end else begin
          w_issue     = 1'b0;
        end
      end
      ST_RD_BURST: begin
        if ((r_issued < r_length) && w_space) begin
          w_issue = 1'b1;
        end else begin
          w_issue = 1'b0;
        end
      end
      ST_WR_BURST: begin
        dma_write_chnl_ready = (r_length != 32'd0);
        w_sram_we            = dma_write_chnl_valid & (r_length != 32'd0);
      end
      default: busy = 1'b0;
    endcase
  end

  // Burst bookkeeping: latched request plus issued/delivered beat counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_index  <= 32'd0;
      r_length <= 32'd0;
      r_issued <= 32'd0;
      r_done   <= 32'd0;
    end else if (w_rd_hs) begin
      r_index  <= dma_read_ctrl_data_index;
      r_length <= dma_read_ctrl_data_length;
      r_issued <= (dma_read_ctrl_data_length != 32'd0) ? 32'd1 : 32'd0;
      r_done   <= 32'd0;
    end else if (w_wr_hs) begin
      r_index  <= dma_write_ctrl_data_index;
      r_length <= dma_write_ctrl_data_length;
      r_issued <= 32'd0;
      r_done   <= 32'd0;
    end else begin
      if (w_issue || w_wr_beat) begin
        r_issued <= r_issued + 32'd1;
      end
      if (w_pop) begin
        r_done <= r_done + 32'd1;
      end
    end
  end

  // Sticky error flags, sampled on each accepted request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 2'b00;
    end else if (w_rd_hs) begin
      r_err[ERR_BAD_SIZE] <= r_err[ERR_BAD_SIZE] | (dma_read_ctrl_data_size != DMA_SIZE_WORD);
      r_err[ERR_RANGE]    <= r_err[ERR_RANGE] | range_err(dma_read_ctrl_data_index,
                                 dma_read_ctrl_data_length, 33'(MEM_WORDS));
    end else if (w_wr_hs) begin
      r_err[ERR_BAD_SIZE] <= r_err[ERR_BAD_SIZE] | (dma_write_ctrl_data_size != DMA_SIZE_WORD);
      r_err[ERR_RANGE]    <= r_err[ERR_RANGE] | range_err(dma_write_ctrl_data_index,
                                 dma_write_ctrl_data_length, 33'(MEM_WORDS));
    end
  end

  // Output register with skid slot: SRAM data lands in the output when it is
  // free or draining, otherwise it parks in the skid slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend   <= 1'b0;
      r_out_v  <= 1'b0;
      r_skid_v <= 1'b0;
      r_out_d  <= 32'd0;
      r_skid_d <= 32'd0;
    end else begin
      r_pend <= w_issue;
      if (!r_out_v || w_pop) begin
        if (r_skid_v) begin
          r_out_d  <= r_skid_d;
          r_out_v  <= 1'b1;
          r_skid_v <= r_pend;
          if (r_pend) begin
            r_skid_d <= w_sram_rdata;
          end
        end else if (r_pend) begin
          r_out_d <= w_sram_rdata;
          r_out_v <= 1'b1;
        end else begin
          r_out_v <= 1'b0;
        end
      end else if (r_pend) begin
        r_skid_d <= w_sram_rdata;
        r_skid_v <= 1'b1;
      end
    end
  end

  esp_dma32_sram #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_addr  (w_sram_addr),
    .i_wdata (dma_write_chnl_data),
    .o_rdata (w_sram_rdata)
  );

endmodule

// File: doc/esp_dma32_responder.md
ESP_DMA32_RESPONDER -- requirements
Module: esp_dma32_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit words in backing memory (power of two, 16..65536).
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports dma_read_ctrl_valid in 1, dma_read_ctrl_ready out 1, dma_read_ctrl_data_index in 32 (word index), dma_read_ctrl_data_length in 32 (beats), dma_read_ctrl_data_size in 3: read request channel.
REQ-005 SHALL have ports dma_read_chnl_valid out 1, dma_read_chnl_data out 32, dma_read_chnl_ready in 1: read data toward accelerator.
REQ-006 SHALL have ports dma_write_ctrl_valid in 1, dma_write_ctrl_ready out 1, dma_write_ctrl_data_index in 32, dma_write_ctrl_data_length in 32, dma_write_ctrl_data_size in 3: write request channel.
REQ-007 SHALL have ports dma_write_chnl_valid in 1, dma_write_chnl_data in 32, dma_write_chnl_ready out 1: write data from accelerator.
REQ-008 SHALL have ports busy out 1 (FSM not IDLE) and err out 2 (bit0 bad size, bit1 out-of-range), sticky.

Function
REQ-009 SHALL use FSM states IDLE, RD_BURST, WR_BURST; transfer on any channel occurs only when valid and ready are both high in the same cycle.
REQ-010 SHALL assert both ctrl_ready signals only in IDLE; when both ctrl_valid are high in IDLE, read SHALL win and write ctrl_ready SHALL drop that cycle.
REQ-011 SHALL, on ctrl handshake, latch index and length into 32-bit registers and enter RD_BURST or WR_BURST; length 0 SHALL return to IDLE next cycle with no beats.
REQ-012 SHALL address beat k at (index + k) modulo MEM_WORDS; if index + length > MEM_WORDS (computed 33-bit), err[1] SHALL set at handshake and the transfer SHALL still complete with wrapped addresses.
REQ-013 SHALL treat any size other than 3'b010 as word size and set err[0] at handshake.
REQ-014 SHALL present first read beat (dma_read_chnl_valid high) exactly 2 cycles after read ctrl handshake (1 cycle SRAM latency + output register).
REQ-015 SHALL sustain one read beat per cycle while dma_read_chnl_ready stays high, using a 2-entry output buffer; data and valid SHALL hold stable while valid high and ready low.
REQ-016 SHALL never issue more read beats than length and SHALL return to IDLE the cycle after the last beat handshake.
REQ-017 SHALL hold dma_write_chnl_ready high throughout WR_BURST and write each accepted beat to SRAM in the handshake cycle; return to IDLE after beat length-1 is accepted.
REQ-018 SHALL clear err only by reset; err bits accumulate across transfers.
REQ-019 SHALL ignore dma_write_chnl_valid outside WR_BURST (ready low, no write).

Reset
REQ-020 SHALL, while rst low, force state IDLE, all valid/ready outputs 0, dma_read_chnl_data 0, busy 0, err 0, counters and buffer empty; SRAM contents unaffected.
REQ-021 SHALL, on reset mid-burst, abandon the transfer; after release, first cycle SHALL show ctrl_ready high.

Structure
REQ-022 SHALL place state encoding, DMA size constant (3'b010) and err bit positions in shared package esp_dma32_pkg.
REQ-023 SHALL instantiate one sub-module esp_dma32_sram: single-port synchronous RAM, MEM_WORDS x 32, 1-cycle read latency, write-first not required.

Verification
REQ-024 Write index 8 length 4 data A0..A3, then read index 8 length 4 with ready held high -> chnl_valid at T+2, beats A0..A3 on 4 consecutive cycles, busy low after.
REQ-025 Read length 6 with ready toggling 1,0,0,1,... -> no beat lost or duplicated, data stable during stalls, exactly 6 handshakes.
REQ-026 Both ctrl_valid high in same IDLE cycle -> read accepted, write accepted only after read burst completes.
REQ-027 Write index MEM_WORDS-2 length 4 size 3'b000 -> err = 2'b11, words land at MEM_WORDS-2, MEM_WORDS-1, 0, 1.
REQ-028 Read length 0 -> no chnl_valid, busy high one cycle; reset asserted mid 16-beat read -> all outputs 0 immediately, ctrl_ready high after release, err 0.
